// File: rtl/msg_word_sequencer_pkg.sv
// ============================================================================
// Module : msg_word_sequencer_pkg
// Brief  : Shared sync bytes, state encodings and slot limits for the
//          receive/transmit message sequencers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package msg_word_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t c_StIdle  = 2'd0;
  localparam state_t c_StSync2 = 2'd1;
  localparam state_t c_StId    = 2'd2;
  localparam state_t c_StData  = 2'd3;

  localparam logic [7:0] c_Sync1Default = 8'h12;
  localparam logic [7:0] c_Sync2Default = 8'h34;

  localparam int c_MaxSlots = 16;

  function automatic logic isSlotValid(input logic [7:0] id, input int numSlots);
    return int'({24'd0, id}) < numSlots;
  endfunction

endpackage

`default_nettype wire

// File: rtl/msg_word_sequencer_timer.sv
// ============================================================================
// Module : msg_word_sequencer_timer
// Brief  : Stall timer; pulses o_expired after TimeoutClocks enabled clocks
//          without a clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module msg_word_sequencer_timer #(
  parameter int TimeoutClocks = 100000
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CntW = $clog2(TimeoutClocks + 1);
  localparam logic [CntW-1:0] c_limit = CntW'(TimeoutClocks - 1);

  logic [CntW-1:0] r_count;

  // Expiry is seen on the clock that would complete the TimeoutClocks-th idle cycle.
  assign o_expired = i_enable && !i_clear && (r_count == c_limit);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count <= '0;
    end else if (i_clear || !i_enable || o_expired) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/msg_word_sequencer.sv
// ============================================================================
// Module : msg_word_sequencer
// Brief  : Parses sync/ID/payload bytes from the UART receiver and sequences
//          the word-assembly slots; all outputs registered.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module msg_word_sequencer
  import msg_word_sequencer_pkg::*;
#(
  parameter int         BytesPerWord  = 4,
  parameter int         NumSlots      = 4,
  parameter int         TimeoutClocks = 100000,
  parameter logic [7:0] Sync1         = c_Sync1Default,
  parameter logic [7:0] Sync2         = c_Sync2Default
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                ByteReady,
  input  logic [7:0]          ByteIn,
  output logic                ClearAddr,
  output logic [NumSlots-1:0] WriteByte,
  output logic [7:0]          DataByte,
  output logic [NumSlots-1:0] MsgDone,
  output logic                BadId,
  output logic                Timeout,
  output logic                Busy
);

  localparam int CntW  = $clog2(BytesPerWord + 1);
  localparam int SlotW = $clog2(c_MaxSlots);
  localparam logic [CntW-1:0] c_lastByte = CntW'(BytesPerWord - 1);

  state_t              r_state;
  state_t              w_nextState;
  logic [SlotW-1:0]    r_slot;
  logic [CntW-1:0]     r_byteCnt;
  logic                r_donePending;
  logic                w_expired;
  logic                w_idValid;
  logic                w_lastByte;
  logic [NumSlots-1:0] w_slotOneHot;
  logic                w_clearAddr;
  logic                w_badId;
  logic                w_timeout;
  logic [NumSlots-1:0] w_writeByte;
  logic [NumSlots-1:0] w_msgDone;
  logic [7:0]          w_dataByte;

  assign w_idValid    = isSlotValid(ByteIn, NumSlots);
  assign w_lastByte   = (r_byteCnt == c_lastByte);
  assign w_slotOneHot = NumSlots'(1) << r_slot;

  msg_word_sequencer_timer #(
    .TimeoutClocks(TimeoutClocks)
  ) u_timer (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .i_clear  (ByteReady),
    .i_enable (r_state != c_StIdle),
    .o_expired(w_expired)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_StIdle:
        if (ByteReady && ByteIn == Sync1) w_nextState = c_StSync2;
      c_StSync2:
        if (ByteReady) begin
          if (ByteIn == Sync2)      w_nextState = c_StId;
          else if (ByteIn != Sync1) w_nextState = c_StIdle;
        end else if (w_expired) begin
          w_nextState = c_StIdle;
        end
      c_StId:
        if (ByteReady)      w_nextState = w_idValid ? c_StData : c_StIdle;
        else if (w_expired) w_nextState = c_StIdle;
      default:
        if (ByteReady) begin
          if (w_lastByte) w_nextState = c_StIdle;
        end else if (w_expired) begin
          w_nextState = c_StIdle;
        end
    endcase
  end

  // Completion is flagged one clock late, so the FSM is already free to parse
  // the next header while MsgDone is being issued.
  always_comb begin
    w_clearAddr = (r_state == c_StId) && ByteReady && w_idValid;
    w_badId     = (r_state == c_StId) && ByteReady && !w_idValid;
    w_timeout   = w_expired;
    w_writeByte = ((r_state == c_StData) && ByteReady) ? w_slotOneHot : '0;
    w_msgDone   = r_donePending ? w_slotOneHot : '0;
    w_dataByte  = DataByte;
    if ((r_state == c_StData) && ByteReady) w_dataByte = ByteIn;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= c_StIdle;
      r_slot        <= '0;
      r_byteCnt     <= '0;
      r_donePending <= 1'b0;
      ClearAddr     <= 1'b0;
      WriteByte     <= '0;
      DataByte      <= '0;
      MsgDone       <= '0;
      BadId         <= 1'b0;
      Timeout       <= 1'b0;
      Busy          <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_donePending <= (r_state == c_StData) && ByteReady && w_lastByte;
      ClearAddr     <= w_clearAddr;
      WriteByte     <= w_writeByte;
      DataByte      <= w_dataByte;
      MsgDone       <= w_msgDone;
      BadId         <= w_badId;
      Timeout       <= w_timeout;
      Busy          <= (w_nextState != c_StIdle);
      if (w_clearAddr) begin
        r_slot    <= ByteIn[SlotW-1:0];
        r_byteCnt <= '0;
      end else if (|w_writeByte) begin
        r_byteCnt <= r_byteCnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_msg_word_sequencer.sv
// ============================================================================
// Module : tb_msg_word_sequencer
// Brief  : Directed vector table plus timeout/reset sequences for
//          msg_word_sequencer (4 slots, 4 bytes per word, short timeout).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_msg_word_sequencer;

  localparam int T = 20;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic       ByteReady;
  logic [7:0] ByteIn;
  logic       ClearAddr;
  logic [3:0] WriteByte;
  logic [7:0] DataByte;
  logic [3:0] MsgDone;
  logic       BadId;
  logic       Timeout;
  logic       Busy;

  int tests = 0;
  int fails = 0;

  msg_word_sequencer #(
    .BytesPerWord (4),
    .NumSlots     (4),
    .TimeoutClocks(T)
  ) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .ByteReady(ByteReady),
    .ByteIn   (ByteIn),
    .ClearAddr(ClearAddr),
    .WriteByte(WriteByte),
    .DataByte (DataByte),
    .MsgDone  (MsgDone),
    .BadId    (BadId),
    .Timeout  (Timeout),
    .Busy     (Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       rdy;
    logic [7:0] b;
    logic [11:0] exp;   // {clr, wr[3:0], done[3:0], bad, to, busy}
    logic [7:0] data;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] pack(input logic clr, input logic [3:0] wr,
                                       input logic [3:0] dn, input logic bad,
                                       input logic to, input logic busy);
    return {clr, wr, dn, bad, to, busy};
  endfunction

  function automatic logic [11:0] observed();
    return {ClearAddr, WriteByte, MsgDone, BadId, Timeout, Busy};
  endfunction

  task automatic add(input logic r, input logic [7:0] b, input logic clr,
                     input logic [3:0] wr, input logic [7:0] d, input logic [3:0] dn,
                     input logic bad, input logic to, input logic busy);
    vec_t v;
    v.rdy = r; v.b = b; v.exp = pack(clr, wr, dn, bad, to, busy); v.data = d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {clr,wr,done,bad,to,busy}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic checkData(input string name, input logic [7:0] exp);
    tests++;
    if (DataByte !== exp) begin
      fails++;
      $display("FAIL %s: DataByte got %h expected %h", name, DataByte, exp);
    end
  endtask

  // Drive one byte (or idle), then sample #1 after the capturing edge.
  task automatic step(input logic r, input logic [7:0] b);
    ByteReady = r;
    ByteIn    = b;
    @(posedge Clock);
    #1;
    ByteReady = 1'b0;
    ByteIn    = 8'h00;
  endtask

  task automatic runIdle(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 8'h00);
      check(name, observed(), pack(0, 4'h0, 4'h0, 0, 0, 1));
    end
  endtask

  task automatic sendMsg(input logic [7:0] id, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3, input logic [3:0] oh);
    step(1, 8'h12); step(1, 8'h34);
    step(1, id);   check("msg_clear", observed(), pack(1, 4'h0, 4'h0, 0, 0, 1));
    step(1, d0);   check("msg_w0", observed(), pack(0, oh, 4'h0, 0, 0, 1)); checkData("msg_d0", d0);
    step(1, d1);   step(1, d2);
    step(1, d3);   check("msg_w3", observed(), pack(0, oh, 4'h0, 0, 0, 0)); checkData("msg_d3", d3);
    step(0, 8'h00); check("msg_done", observed(), pack(0, 4'h0, oh, 0, 0, 0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; ByteReady = 1'b0; ByteIn = 8'h00;
    // 1: slot 1, AA..DD
    add(1,8'h12,0,4'h0,0,0,0,0,1); add(1,8'h34,0,4'h0,0,0,0,0,1);
    add(1,8'h01,1,4'h0,0,0,0,0,1); add(1,8'hAA,0,4'h2,8'hAA,0,0,0,1);
    add(1,8'hBB,0,4'h2,8'hBB,0,0,0,1); add(1,8'hCC,0,4'h2,8'hCC,0,0,0,1);
    add(1,8'hDD,0,4'h2,8'hDD,0,0,0,0); add(0,8'h00,0,4'h0,0,4'h2,0,0,0);
    add(0,8'h00,0,4'h0,0,0,0,0,0);
    // 2: repeated Sync1, slot 0
    add(1,8'h12,0,4'h0,0,0,0,0,1); add(1,8'h12,0,4'h0,0,0,0,0,1);
    add(1,8'h34,0,4'h0,0,0,0,0,1); add(1,8'h00,1,4'h0,0,0,0,0,1);
    add(1,8'h11,0,4'h1,8'h11,0,0,0,1); add(1,8'h22,0,4'h1,8'h22,0,0,0,1);
    add(1,8'h33,0,4'h1,8'h33,0,0,0,1); add(1,8'h44,0,4'h1,8'h44,0,0,0,0);
    add(0,8'h00,0,4'h0,0,4'h1,0,0,0);
    // 3: bad IDs 07 and 04, then a good message to slot 3
    add(1,8'h12,0,4'h0,0,0,0,0,1); add(1,8'h34,0,4'h0,0,0,0,0,1);
    add(1,8'h07,0,4'h0,0,0,1,0,0); add(0,8'h00,0,4'h0,0,0,0,0,0);
    add(1,8'h12,0,4'h0,0,0,0,0,1); add(1,8'h34,0,4'h0,0,0,0,0,1);
    add(1,8'h04,0,4'h0,0,0,1,0,0);
    add(1,8'h12,0,4'h0,0,0,0,0,1); add(1,8'h34,0,4'h0,0,0,0,0,1);
    add(1,8'h03,1,4'h0,0,0,0,0,1); add(1,8'h01,0,4'h8,8'h01,0,0,0,1);
    add(1,8'h02,0,4'h8,8'h02,0,0,0,1); add(1,8'h03,0,4'h8,8'h03,0,0,0,1);
    add(1,8'h04,0,4'h8,8'h04,0,0,0,0); add(0,8'h00,0,4'h0,0,4'h8,0,0,0);
    // header mismatches: stray Sync2 in IDLE, bad second sync, Sync1 as an ID
    add(1,8'h34,0,4'h0,0,0,0,0,0); add(1,8'h12,0,4'h0,0,0,0,0,1);
    add(1,8'h55,0,4'h0,0,0,0,0,0); add(1,8'h12,0,4'h0,0,0,0,0,1);
    add(1,8'h34,0,4'h0,0,0,0,0,1); add(1,8'h12,0,4'h0,0,0,1,0,0);
    // 6: back-to-back strobes, slot 1 then slot 2
    add(1,8'h12,0,4'h0,0,0,0,0,1); add(1,8'h34,0,4'h0,0,0,0,0,1);
    add(1,8'h01,1,4'h0,0,0,0,0,1); add(1,8'hA1,0,4'h2,8'hA1,0,0,0,1);
    add(1,8'hA2,0,4'h2,8'hA2,0,0,0,1); add(1,8'hA3,0,4'h2,8'hA3,0,0,0,1);
    add(1,8'hA4,0,4'h2,8'hA4,0,0,0,0); add(1,8'h12,0,4'h0,0,4'h2,0,0,1);
    add(1,8'h34,0,4'h0,0,0,0,0,1); add(1,8'h02,1,4'h0,0,0,0,0,1);
    add(1,8'hB1,0,4'h4,8'hB1,0,0,0,1); add(1,8'hB2,0,4'h4,8'hB2,0,0,0,1);
    add(1,8'hB3,0,4'h4,8'hB3,0,0,0,1); add(1,8'hB4,0,4'h4,8'hB4,0,0,0,0);
    add(0,8'h00,0,4'h0,0,4'h4,0,0,0); add(0,8'h00,0,4'h0,0,0,0,0,0);

    repeat (2) @(posedge Clock);
    #1;
    check("reset_state", observed(), 12'h000);
    checkData("reset_data", 8'h00);
    Reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].rdy, vecs[i].b);
      check($sformatf("vec%0d", i), observed(), vecs[i].exp);
      if (vecs[i].exp[10:7] != 4'h0) checkData($sformatf("vec%0d_data", i), vecs[i].data);
    end

    // 4: stall in DATA after two bytes -> Timeout exactly T idle clocks later
    step(1, 8'h12); step(1, 8'h34); step(1, 8'h02); step(1, 8'hAA); step(1, 8'hBB);
    runIdle("to_wait", T - 1);
    step(0, 8'h00); check("to_pulse", observed(), pack(0, 4'h0, 4'h0, 0, 1, 0));
    step(0, 8'h00); check("to_after", observed(), 12'h000);

    // stall in SYNC2 also times out
    step(1, 8'h12);
    runIdle("to_sync2_wait", T - 1);
    step(0, 8'h00); check("to_sync2_pulse", observed(), pack(0, 4'h0, 4'h0, 0, 1, 0));

    // byte on the would-be timeout clock wins and the message completes
    step(1, 8'h12); step(1, 8'h34); step(1, 8'h02); step(1, 8'hAA);
    runIdle("win_wait", T - 1);
    step(1, 8'hBB); check("win_byte", observed(), pack(0, 4'h4, 4'h0, 0, 0, 1));
    checkData("win_data", 8'hBB);
    step(1, 8'hCC); step(1, 8'hDD);
    step(0, 8'h00); check("win_done", observed(), pack(0, 4'h0, 4'h4, 0, 0, 0));

    // 5: asynchronous reset mid-message, then a clean message
    step(1, 8'h12); step(1, 8'h34); step(1, 8'h03); step(1, 8'h11); step(1, 8'h22);
    check("rst_pre", observed(), pack(0, 4'h8, 4'h0, 0, 0, 1));
    #1 Reset_n = 1'b0;
    #1 check("rst_async", observed(), 12'h000);
    checkData("rst_data", 8'h00);
    @(posedge Clock); #1 Reset_n = 1'b1;
    sendMsg(8'h03, 8'h5A, 8'h6B, 8'h7C, 8'h8D, 4'h8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
